ifetch_queue: RTL and testbench

- Parametrised instruction-fetch front end.
- Decouples icache fetch from decoder dispatch through a QUEUE_DEPTH-entry instruction queue.
- Computes next PC locally: pc+2/pc+4, JAL/C.J/C.JAL targets, and predicted branch targets.
- Stalls on JALR until the ROB resolves it; flushes queue and in-flight fetch on branch mispredict.
- Sits between icache, predictor, decoder and ROB.

---
 rtl/ifetch_queue.sv | 202 ++++++++++++++++++++
 tb/tb_ifetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: one outstanding icache request, local next-PC
// computation, and a circular instruction queue feeding the decoder.
module ifetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter bit          EN_RVC      = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        to_icache,
  output logic [31:0] pc_to_icache,
  input  logic        have_result,
  input  logic [31:0] inst_from_icache,
  output logic [31:0] pc_to_predictor,
  input  logic        predict,
  output logic        to_decoder,
  output logic [31:0] inst,
  output logic [31:0] pc_to_decoder,
  output logic        is_c,
  output logic        predict_result,
  input  logic        received,
  output logic        update,
  output logic [31:0] update_pc,
  output logic        update_result,
  input  logic        jalr_finish,
  input  logic        branch_finish,
  input  logic [31:0] next_pc_from_rob,
  input  logic [31:0] branch_pc_from_rob,
  input  logic        prejudge,
  input  logic        branch_result
);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, JSTALL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               discard_q, discard_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d, count_after_pop;
  logic [31:0]        inst_mem [QUEUE_DEPTH];
  logic [31:0]        pc_mem   [QUEUE_DEPTH];
  logic               c_mem    [QUEUE_DEPTH];
  logic               pred_mem [QUEUE_DEPTH];

  logic               to_icache_q, to_decoder_q, is_c_q, pred_q;
  logic [31:0]        pc_to_icache_q, inst_q, pc_dec_q;
  logic               update_q, update_result_q;
  logic [31:0]        update_pc_q;
  logic               req, push, pop, mispredict;

  // Decode of the arriving word
  logic [31:0] w, push_word, seq_pc, fetch_next;
  logic [31:0] j_imm, b_imm, cj_imm, cb_imm;
  logic        w_c, is_jal, is_jalr, is_br, is_cj, is_cb, is_cjr, push_pred;

  always_comb begin
    w         = inst_from_icache;
    w_c       = EN_RVC && (w[1:0] != 2'b11);
    push_word = w_c ? {16'b0, w[15:0]} : w;
    seq_pc    = pc_q + (w_c ? 32'd2 : 32'd4);
    j_imm     = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    b_imm     = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    cj_imm    = {{21{w[12]}}, w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0};
    cb_imm    = {{24{w[12]}}, w[6:5], w[2], w[11:10], w[4:3], 1'b0};
    is_jal    = !w_c && (w[6:0] == 7'b1101111);
    is_jalr   = !w_c && (w[6:0] == 7'b1100111);
    is_br     = !w_c && (w[6:0] == 7'b1100011);
    is_cj     = w_c && (w[1:0] == 2'b01) && ((w[15:13] == 3'b101) || (w[15:13] == 3'b001));
    is_cb     = w_c && (w[1:0] == 2'b01) && (w[15:14] == 2'b11);
    is_cjr    = w_c && (w[1:0] == 2'b10) && (w[15:13] == 3'b100) &&
                (w[11:7] != 5'd0) && (w[6:2] == 5'd0);
    push_pred = (is_br || is_cb) && predict;
    if (is_jal)                fetch_next = pc_q + j_imm;
    else if (is_cj)            fetch_next = pc_q + cj_imm;
    else if (is_br && predict) fetch_next = pc_q + b_imm;
    else if (is_cb && predict) fetch_next = pc_q + cb_imm;
    else                       fetch_next = seq_pc;
  end

  always_comb begin
    mispredict      = branch_finish && (prejudge != branch_result);
    pop             = received && (count_q != '0);
    count_after_pop = count_q - CNT_W'(pop);
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    push      = 1'b0;
    req       = 1'b0;
    if (mispredict) begin
      pc_d    = next_pc_from_rob;
      state_d = IDLE;
      // An outstanding fetch still owes a response; remember to drop it.
      discard_d = (state_q == WAIT) ? !have_result : (discard_q && !have_result);
    end else begin
      case (state_q)
        IDLE: begin
          if (discard_q) begin
            if (have_result) discard_d = 1'b0;
          end else if (count_after_pop < CNT_W'(QUEUE_DEPTH)) begin
            req     = 1'b1;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (have_result) begin
            push    = 1'b1;
            pc_d    = fetch_next;
            state_d = (is_jalr || is_cjr) ? JSTALL : IDLE;
          end
        end
        JSTALL: begin
          if (jalr_finish) begin
            pc_d    = next_pc_from_rob;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push);
      count_d = count_after_pop + CNT_W'(push);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && push) begin
      inst_mem[tail_q] <= push_word;
      pc_mem[tail_q]   <= pc_q;
      c_mem[tail_q]    <= w_c;
      pred_mem[tail_q] <= push_pred;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      discard_q       <= 1'b0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      to_icache_q     <= 1'b0;
      pc_to_icache_q  <= '0;
      to_decoder_q    <= 1'b0;
      inst_q          <= '0;
      pc_dec_q        <= '0;
      is_c_q          <= 1'b0;
      pred_q          <= 1'b0;
      update_q        <= 1'b0;
      update_pc_q     <= '0;
      update_result_q <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      to_icache_q <= req;
      if (req) pc_to_icache_q <= pc_q;
      to_decoder_q <= (count_d != '0);
      // A push into an empty queue becomes the head directly.
      if (push && (count_after_pop == '0)) begin
        inst_q   <= push_word;
        pc_dec_q <= pc_q;
        is_c_q   <= w_c;
        pred_q   <= push_pred;
      end else if (count_d != '0) begin
        inst_q   <= inst_mem[head_d];
        pc_dec_q <= pc_mem[head_d];
        is_c_q   <= c_mem[head_d];
        pred_q   <= pred_mem[head_d];
      end
      update_q <= branch_finish;
      if (branch_finish) begin
        update_pc_q     <= branch_pc_from_rob;
        update_result_q <= branch_result;
      end
    end
  end

  assign to_icache       = to_icache_q;
  assign pc_to_icache    = pc_to_icache_q;
  assign pc_to_predictor = pc_q;
  assign to_decoder      = to_decoder_q;
  assign inst            = inst_q;
  assign pc_to_decoder   = pc_dec_q;
  assign is_c            = is_c_q;
  assign predict_result  = pred_q;
  assign update          = update_q;
  assign update_pc       = update_pc_q;
  assign update_result   = update_result_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: icache responses are driven by hand, the
// expected queue entries are scoreboarded and compared as the decoder pops them.
module tb_ifetch_queue;
  logic        clk = 1'b0;
  logic        rst_in, rdy_in;
  logic        to_icache;
  logic [31:0] pc_to_icache;
  logic        have_result;
  logic [31:0] inst_from_icache;
  logic [31:0] pc_to_predictor;
  logic        predict;
  logic        to_decoder;
  logic [31:0] inst, pc_to_decoder;
  logic        is_c, predict_result, received;
  logic        update;
  logic [31:0] update_pc;
  logic        update_result, jalr_finish, branch_finish;
  logic [31:0] next_pc_from_rob, branch_pc_from_rob;
  logic        prejudge, branch_result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        c;
    logic        p;
  } ent_t;
  ent_t        sb[$];
  logic [31:0] reqs[$];

  localparam logic [31:0] ADDI  = 32'h00150513;
  localparam logic [31:0] CADDI = 32'hABCD0505;
  localparam logic [31:0] BEQ   = 32'h02000063;  // beq x0,x0,+0x20
  localparam logic [31:0] JAL   = 32'h0400006F;  // jal x0,+0x40
  localparam logic [31:0] JALR  = 32'h00008067;
  localparam logic [31:0] CJ    = 32'h0000A021;  // c.j +8

  ifetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h0), .EN_RVC(1'b1)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .to_icache(to_icache), .pc_to_icache(pc_to_icache),
    .have_result(have_result), .inst_from_icache(inst_from_icache),
    .pc_to_predictor(pc_to_predictor), .predict(predict),
    .to_decoder(to_decoder), .inst(inst), .pc_to_decoder(pc_to_decoder),
    .is_c(is_c), .predict_result(predict_result), .received(received),
    .update(update), .update_pc(update_pc), .update_result(update_result),
    .jalr_finish(jalr_finish), .branch_finish(branch_finish),
    .next_pc_from_rob(next_pc_from_rob), .branch_pc_from_rob(branch_pc_from_rob),
    .prejudge(prejudge), .branch_result(branch_result)
  );

  always #5 clk = ~clk;

  // Record every fetch request just after the edge that raises it.
  always begin
    @(posedge clk);
    #1;
    if (to_icache) reqs.push_back(pc_to_icache);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1; received = 1'b0; have_result = 1'b0; predict = 1'b0;
    branch_finish = 1'b0; jalr_finish = 1'b0;
    tick(); tick();
    rst_in = 1'b0;
    reqs.delete();
    sb.delete();
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_pc);
    for (int k = 0; k < 30 && reqs.size() == 0; k++) tick();
    chk({tag, "_seen"}, 32'(reqs.size() != 0), 32'd1);
    if (reqs.size() != 0) begin
      chk(tag, reqs.pop_front(), exp_pc);
      $display("req %s pc=%h", tag, exp_pc);
    end
  endtask

  task automatic drive_resp(input logic [31:0] word, input logic pred);
    have_result = 1'b1; inst_from_icache = word; predict = pred;
    tick();
    have_result = 1'b0; predict = 1'b0; inst_from_icache = 32'hDEADBEEF;
  endtask

  task automatic respond(input logic [31:0] word, input logic [31:0] pc, input logic pred);
    ent_t e;
    e.c   = (word[1:0] != 2'b11);
    e.ins = e.c ? {16'b0, word[15:0]} : word;
    e.pc  = pc;
    e.p   = pred;
    sb.push_back(e);
    drive_resp(word, pred);
  endtask

  task automatic pop_check(input logic do_pop);
    ent_t e;
    for (int k = 0; k < 30 && !to_decoder; k++) tick();
    chk("dec_valid", 32'(to_decoder), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("dec_pc", pc_to_decoder, e.pc);
      chk("dec_inst", inst, e.ins);
      chk("dec_is_c", 32'(is_c), 32'(e.c));
      chk("dec_pred", 32'(predict_result), 32'(e.p));
      $display("pop pc=%h inst=%h is_c=%0d pred=%0d", pc_to_decoder, inst, is_c, predict_result);
    end
    if (do_pop) begin
      received = 1'b1;
      tick();
      received = 1'b0;
    end
  endtask

  initial begin
    rdy_in = 1'b1; rst_in = 1'b1; received = 1'b0; have_result = 1'b0;
    inst_from_icache = '0; predict = 1'b0; jalr_finish = 1'b0; branch_finish = 1'b0;
    next_pc_from_rob = '0; branch_pc_from_rob = '0; prejudge = 1'b0; branch_result = 1'b0;
    tick();
    chk("rst_to_icache", 32'(to_icache), 32'd0);
    chk("rst_to_decoder", 32'(to_decoder), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_pc_pred", pc_to_predictor, 32'h0);

    // Straight-line 32-bit stream, decoder draining each entry
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_req("seq_req", 32'(4 * i));
      respond(ADDI, 32'(4 * i), 1'b0);
      pop_check(1'b1);
    end

    // Decoder stalled: exactly four fetches, then one pop frees one slot
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_req("fill_req", 32'(4 * i));
      respond(ADDI, 32'(4 * i), 1'b0);
    end
    repeat (8) tick();
    chk("full_no_req", 32'(reqs.size()), 32'd0);
    chk("full_to_icache", 32'(to_icache), 32'd0);
    pop_check(1'b1);
    wait_req("refill_req", 32'h10);
    respond(ADDI, 32'h10, 1'b0);
    for (int i = 0; i < 4; i++) pop_check(1'b1);

    // Mixed compressed / 32-bit lengths
    do_reset();
    wait_req("rvc_req0", 32'h0);
    respond(CADDI, 32'h0, 1'b0);
    wait_req("rvc_req2", 32'h2);
    respond(ADDI, 32'h2, 1'b0);
    wait_req("rvc_req6", 32'h6);
    pop_check(1'b1);
    pop_check(1'b1);

    // Predicted-taken BEQ, then a mispredict with a fetch outstanding
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_req("pre_req", 32'(4 * i));
      respond(ADDI, 32'(4 * i), 1'b0);
      pop_check(1'b1);
    end
    wait_req("beq_req", 32'h10);
    respond(BEQ, 32'h10, 1'b1);
    wait_req("beq_target", 32'h30);
    pop_check(1'b0);
    branch_finish = 1'b1; prejudge = 1'b1; branch_result = 1'b0;
    next_pc_from_rob = 32'h14; branch_pc_from_rob = 32'h10;
    tick();
    branch_finish = 1'b0;
    chk("flush_to_decoder", 32'(to_decoder), 32'd0);
    chk("upd_strobe", 32'(update), 32'd1);
    chk("upd_pc", update_pc, 32'h10);
    chk("upd_result", 32'(update_result), 32'd0);
    tick();
    chk("upd_clear", 32'(update), 32'd0);
    repeat (3) tick();
    chk("discard_no_req", 32'(reqs.size()), 32'd0);
    drive_resp(ADDI, 1'b0);
    tick();
    chk("late_dropped", 32'(to_decoder), 32'd0);
    wait_req("redirect_req", 32'h14);

    // JAL to 0x40, JALR stall until resolved, then C.J
    do_reset();
    wait_req("jal_req", 32'h0);
    respond(JAL, 32'h0, 1'b0);
    wait_req("jal_target", 32'h40);
    respond(JALR, 32'h40, 1'b0);
    repeat (10) tick();
    chk("jstall_no_req", 32'(reqs.size()), 32'd0);
    jalr_finish = 1'b1; next_pc_from_rob = 32'h100;
    tick();
    jalr_finish = 1'b0;
    wait_req("jalr_target", 32'h100);
    respond(CJ, 32'h100, 1'b0);
    wait_req("cj_target", 32'h108);
    for (int i = 0; i < 3; i++) pop_check(1'b1);

    // Asynchronous reset while a fetch is outstanding
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wait_req("ar_fill", 32'(4 * i));
      respond(ADDI, 32'(4 * i), 1'b0);
    end
    wait_req("ar_wait", 32'hC);
    #2 rst_in = 1'b1;
    #1;
    chk("ar_to_decoder", 32'(to_decoder), 32'd0);
    chk("ar_inst", inst, 32'h0);
    chk("ar_pc_dec", pc_to_decoder, 32'h0);
    chk("ar_pc_pred", pc_to_predictor, 32'h0);
    tick();
    rst_in = 1'b0;
    reqs.delete();
    sb.delete();
    wait_req("ar_restart", 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
